// File: rtl/cntr_updown_param_pkg.sv
// cntr_updown_param_pkg: shared FSM state encoding for the up/down counter.
package cntr_updown_param_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        INC2 = 3'b011,
        DEC  = 3'b100,
        DEC2 = 3'b101
    } state_e;
endpackage

// File: rtl/cntr_ns_logic.sv
// cntr_ns_logic: combinational next-state decode for the up/down counter FSM.
module cntr_ns_logic
    import cntr_updown_param_pkg::*;
(
    input  logic               load,
    input  logic               en,
    input  logic               inc,
    input  logic [STATE_W-1:0] state,
    output state_e             next_state
);
    // Unused codes 110/111 fall back to IDLE unless a load overrides them.
    always_comb begin
        next_state = IDLE;
        if (load)
            next_state = LOAD;
        else if (!en || state > DEC2)
            next_state = IDLE;
        else if (inc)
            next_state = (state == INC || state == INC2) ? INC2 : INC;
        else
            next_state = (state == DEC || state == DEC2) ? DEC2 : DEC;
    end
endmodule

// File: rtl/cntr_updown_param.sv
// cntr_updown_param: parametrised up/down counter with two step sizes,
// wrap or saturate overflow handling, and terminal-count/overflow flags.
module cntr_updown_param
    import cntr_updown_param_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int BIG_STEP = 2,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               load,
    input  logic               inc,
    input  logic [WIDTH-1:0]   d_in,
    output logic [WIDTH-1:0]   d_out,
    output logic [STATE_W-1:0] o_state,
    output logic               o_tc,
    output logic               o_ovf
);
    localparam logic [WIDTH:0] BIG = (WIDTH + 1)'(BIG_STEP);
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);
    state_e           state, next_state;
    logic             up, dn, ovf_n, tc_n;
    logic [WIDTH:0]   step, sum, diff;
    logic [WIDTH-1:0] cnt_n;
    cntr_ns_logic u_ns (
        .load       (load),
        .en         (en),
        .inc        (inc),
        .state      (state),
        .next_state (next_state)
    );
    // One spare bit on the add/subtract exposes carry-out and borrow directly.
    always_comb begin
        up    = next_state == INC || next_state == INC2;
        dn    = next_state == DEC || next_state == DEC2;
        step  = (next_state == INC2 || next_state == DEC2) ? BIG : ONE;
        sum   = {1'b0, d_out} + step;
        diff  = {1'b0, d_out} - step;
        ovf_n = (up && sum[WIDTH]) || (dn && diff[WIDTH]);
        cnt_n = next_state == LOAD ? d_in :
                up ? ((sum[WIDTH] && SATURATE != 0) ? '1 : sum[WIDTH-1:0]) :
                dn ? ((diff[WIDTH] && SATURATE != 0) ? '0 : diff[WIDTH-1:0]) :
                d_out;
        tc_n  = (up || (!dn && inc)) ? &cnt_n : ~|cnt_n;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            d_out <= '0;
            o_tc  <= 1'b0;
            o_ovf <= 1'b0;
        end else begin
            state <= next_state;
            d_out <= cnt_n;
            o_tc  <= tc_n;
            o_ovf <= ovf_n;
        end
    end
    assign o_state = state;
endmodule
